// File: rtl/sd_dma_axi_writer_if.sv
// AXI4 write-channel bundle between the SD DMA writer (master) and the memory side (slave).
interface sd_dma_axi_writer_if;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      output awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
      input  awready, wready, bresp, bvalid
   );

   modport slave (
      input  awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
      output awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/sd_dma_axi_writer.sv
// Packs the SD read stream into 32-bit words, buffers them in a FWFT FIFO and
// drains the FIFO to memory as AXI4 INCR bursts.
module sd_dma_axi_writer #(
   parameter int BURST_LEN  = 16,
   parameter int FIFO_DEPTH = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [31:0]         base_addr,
   input  logic                wr_en,
   input  logic [15:0]         wr_data,
   input  logic                wr_last,
   output logic                busy,
   output logic                done,
   output logic                overflow,
   output logic                err,
   sd_dma_axi_writer_if.master m
);

   localparam int              PTR_W      = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0]  FULL_CNT   = FIFO_DEPTH[PTR_W:0];
   localparam logic [PTR_W:0]  BURST_CNT  = BURST_LEN[PTR_W:0];
   localparam logic [7:0]      BURST_LEN8 = BURST_LEN[7:0];

   typedef enum logic [2:0] {IDLE, ARM, AW, W, B, DONE} state_t;

   state_t            state, next_state;
   logic [31:0]       cur_addr;
   logic [7:0]        len, beat, arm_len;
   logic [31:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [PTR_W:0]    count;
   logic              pend_valid;
   logic [15:0]       pend_data;
   logic              wr_last_q, last_rise_q, last_seen;
   logic              push_req, push_ok, pop, full, fifo_clear;
   logic [31:0]       push_word;

   assign full       = (count == FULL_CNT);
   assign fifo_clear = (state == IDLE);
   // A word completes on the 2nd halfword, or one cycle after wr_last rises with a half-word still pending.
   assign push_req   = pend_valid & (wr_en | last_rise_q);
   assign push_word  = wr_en ? {wr_data, pend_data} : {16'h0, pend_data};
   assign push_ok    = push_req & ~full & ~fifo_clear;
   assign pop        = (state == W) & m.wready;
   assign arm_len    = (count >= BURST_CNT) ? BURST_LEN8 : 8'(count);

   always_ff @(posedge clk) begin
      if (rst) wr_last_q <= 1'b0;
      else     wr_last_q <= wr_last;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || fifo_clear) begin
         pend_valid  <= 1'b0;
         pend_data   <= 16'h0;
         last_rise_q <= 1'b0;
         last_seen   <= 1'b0;
      end else begin
         last_rise_q <= wr_last & ~wr_last_q;
         if (last_rise_q) last_seen <= 1'b1;
         if (wr_en) begin
            if (pend_valid) begin
               pend_valid <= 1'b0;
            end else begin
               pend_valid <= 1'b1;
               pend_data  <= wr_data;
            end
         end else if (last_rise_q) begin
            pend_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || fifo_clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: the storage array has no reset; validity is tracked solely by the pointers and count.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_word;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow <= 1'b0;
         err      <= 1'b0;
      end else if (state == IDLE && start) begin
         overflow <= 1'b0;
         err      <= 1'b0;
      end else begin
         if (push_req && full && !fifo_clear)                 overflow <= 1'b1;
         if (state == B && m.bvalid && m.bresp != 2'b00)      err      <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cur_addr <= 32'h0;
         len      <= 8'h0;
         beat     <= 8'h0;
      end else begin
         state <= next_state;
         case (state)
            IDLE: if (start) cur_addr <= base_addr;
            ARM:  if (next_state == AW) begin
                     len  <= arm_len;
                     beat <= 8'h0;
                  end
            W:    if (pop) beat <= beat + 1'b1;
            B:    if (m.bvalid) cur_addr <= cur_addr + {22'h0, len, 2'b00};
            default: ;
         endcase
      end
   end

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      next_state = state;
      busy       = 1'b0;
      done       = 1'b0;
      m.awaddr   = 32'h0;
      m.awlen    = 8'h0;
      m.awsize   = 3'b010;
      m.awburst  = 2'b01;
      m.awvalid  = 1'b0;
      m.wdata    = 32'h0;
      m.wstrb    = 4'hF;
      m.wlast    = 1'b0;
      m.wvalid   = 1'b0;
      m.bready   = 1'b0;
      case (state)
         IDLE: if (start) next_state = ARM;
         ARM: begin
            busy = 1'b1;
            if (!start)                                       next_state = IDLE;
            else if (count >= BURST_CNT)                      next_state = AW;
            else if (last_seen && count != '0)                next_state = AW;
            else if (last_seen && count == '0 && !pend_valid) next_state = DONE;
         end
         AW: begin
            busy      = 1'b1;
            m.awaddr  = cur_addr;
            m.awlen   = len - 8'd1;
            m.awvalid = 1'b1;
            if (m.awready) next_state = W;
         end
         W: begin
            busy     = 1'b1;
            m.wvalid = 1'b1;
            m.wdata  = mem[rd_ptr];
            m.wlast  = (beat == len - 8'd1);
            if (m.wready && beat == len - 8'd1) next_state = B;
         end
         B: begin
            busy     = 1'b1;
            m.bready = 1'b1;
            if (m.bvalid) next_state = ARM;
         end
         DONE: begin
            done = 1'b1;
            if (!start) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

endmodule

// File: tb/tb_sd_dma_axi_writer.sv
// Scoreboard bench for sd_dma_axi_writer: packed words are queued as halfwords are driven
// and popped as the DUT writes them; a negedge AXI slave model supplies ready/response traffic.
module tb_sd_dma_axi_writer;
   logic        clk = 1'b0;
   logic        rst, start, wr_en, wr_last;
   logic [31:0] base_addr;
   logic [15:0] wr_data;
   logic        busy, done, overflow, err;

   sd_dma_axi_writer_if axi ();

   sd_dma_axi_writer #(.BURST_LEN(16), .FIFO_DEPTH(64)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last),
      .busy(busy), .done(done), .overflow(overflow), .err(err), .m(axi)
   );

   always #5 clk = ~clk;

   int          vectors = 0, miscompares = 0;
   logic [31:0] exp_q [$];

   // Per-test context, written by the sequencing initial block only.
   logic [31:0] t_base = 32'h0;
   int          t_words = 0, t_aw0 = 0, t_b0 = 0, t_bad_b = -1;
   bit          t_check_len = 0, t_subseq = 0, t_rand = 0, t_hold_w = 0;

   // Slave-model state, written by the slave process only.
   int          aw_cnt = 0, wlast_cnt = 0, b_cnt = 0, b_issued = 0, beat = 0;
   bit          in_w = 0, b_drop = 0;
   logic [7:0]  cur_len = 8'h0;

   always @(negedge clk) begin : axi_slave
      int          k;
      logic [7:0]  exp_len;
      logic [31:0] got, exp_w;
      bit          found;
      if (b_drop) begin axi.bvalid = 1'b0; b_drop = 0; end
      axi.awready = t_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      axi.wready  = t_hold_w ? 1'b0 : (t_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
      if (rst) begin
         axi.bvalid = 1'b0;
         axi.bresp  = 2'b00;
         b_issued   = wlast_cnt;
      end else if (!axi.bvalid && wlast_cnt > b_issued && (!t_rand || $urandom_range(0, 2) == 0)) begin
         axi.bvalid = 1'b1;
         axi.bresp  = (b_issued - t_b0 == t_bad_b) ? 2'b10 : 2'b00;
         b_issued++;
      end
      #1;
      if (rst) begin
         in_w = 0;
      end else begin
         if (in_w) begin
            vectors++;
            if (axi.wvalid !== 1'b1) begin
               miscompares++;
               $display("FAIL wvalid_gap: got %b required 1 at beat %0d", axi.wvalid, beat);
            end
         end
         if (axi.wvalid === 1'b1 && axi.wready) begin
            vectors++;
            if (axi.wlast !== (beat == int'(cur_len))) begin
               miscompares++;
               $display("FAIL wlast: got %b at beat %0d of awlen %0d", axi.wlast, beat, cur_len);
            end
            got = axi.wdata;
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL wdata_extra: got %h with no word expected", got);
            end else if (t_subseq) begin
               found = 0;
               while (exp_q.size() > 0 && !found) if (exp_q.pop_front() == got) found = 1;
               if (!found) begin
                  miscompares++;
                  $display("FAIL wdata_order: got %h not found in remaining stream", got);
               end
            end else begin
               exp_w = exp_q.pop_front();
               if (got !== exp_w) begin
                  miscompares++;
                  $display("FAIL wdata: got %h required %h", got, exp_w);
               end
            end
            beat++;
            if (axi.wlast) begin in_w = 0; wlast_cnt++; end
         end
         if (axi.awvalid === 1'b1 && axi.awready) begin
            k = aw_cnt - t_aw0;
            vectors++;
            if (axi.awaddr !== t_base + 32'(k) * 32'h40) begin
               miscompares++;
               $display("FAIL awaddr: got %h required %h", axi.awaddr, t_base + 32'(k) * 32'h40);
            end
            if (t_check_len) begin
               exp_len = (k < t_words / 16) ? 8'd15 : 8'(t_words % 16 - 1);
               vectors++;
               if (axi.awlen !== exp_len) begin
                  miscompares++;
                  $display("FAIL awlen: got %0d required %0d (burst %0d)", axi.awlen, exp_len, k);
               end
            end
            cur_len = axi.awlen;
            beat    = 0;
            in_w    = 1;
            aw_cnt++;
         end
         if (axi.bvalid && axi.bready === 1'b1) begin b_cnt++; b_drop = 1; end
      end
   end

   task automatic send_hw(input int n, input bit gaps);
      logic [15:0] prev;
      prev = 16'h0;
      for (int i = 0; i < n; i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) begin @(negedge clk); wr_en = 1'b0; end
         @(negedge clk);
         wr_en   = 1'b1;
         wr_data = 16'($urandom);
         if (i % 2 == 1) exp_q.push_back({wr_data, prev});
         else            prev = wr_data;
      end
      @(negedge clk);
      wr_en = 1'b0;
      if (n % 2 == 1) exp_q.push_back({16'h0, prev});
      @(negedge clk);
      wr_last = 1'b1;
   endtask

   task automatic begin_xfer(input logic [31:0] base, input int words, input bit check_len);
      t_base      = base;
      t_words     = words;
      t_check_len = check_len;
      t_aw0       = aw_cnt;
      t_b0        = b_issued;
      exp_q.delete();
      @(negedge clk);
      base_addr = base;
      start     = 1'b1;
      wr_last   = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic end_xfer();
      @(negedge clk);
      start   = 1'b0;
      wr_last = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget && done !== 1'b1; i++) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; wr_en = 1'b0; wr_last = 1'b0; wr_data = 16'h0; base_addr = 32'h0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({busy, done, overflow, err} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_status: got %b required 0000", {busy, done, overflow, err});
      end
      vectors++;
      if ({axi.awvalid, axi.wvalid, axi.wlast, axi.bready} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_handshake: got %b required 0000", {axi.awvalid, axi.wvalid, axi.wlast, axi.bready});
      end
      vectors++;
      if ({axi.awaddr, axi.awlen, axi.wdata} !== 72'h0) begin
         miscompares++;
         $display("FAIL reset_bus: got %h required 0", {axi.awaddr, axi.awlen, axi.wdata});
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   // Runs one complete transfer and checks burst count and final flags.
   task automatic run_full(input string name, input logic [31:0] base, input int hw, input bit gaps);
      int n_words, n_bursts;
      n_words  = (hw + 1) / 2;
      n_bursts = (n_words + 15) / 16;
      begin_xfer(base, n_words, 1'b1);
      send_hw(hw, gaps);
      wait_done(6000);
      vectors++;
      if (done !== 1'b1) begin
         miscompares++;
         $display("FAIL %s_done: got %b required 1", name, done);
      end
      vectors++;
      if (aw_cnt - t_aw0 !== n_bursts) begin
         miscompares++;
         $display("FAIL %s_bursts: got %0d required %0d", name, aw_cnt - t_aw0, n_bursts);
      end
      vectors++;
      if (exp_q.size() !== 0) begin
         miscompares++;
         $display("FAIL %s_leftover: got %0d words unwritten required 0", name, exp_q.size());
      end
      vectors++;
      if ({busy, overflow, err} !== 3'b000) begin
         miscompares++;
         $display("FAIL %s_flags: got busy/ovf/err %b required 000", name, {busy, overflow, err});
      end
      repeat (4) @(negedge clk);
      vectors++;
      if (done !== 1'b1) begin
         miscompares++;
         $display("FAIL %s_done_hold: got %b required 1", name, done);
      end
      end_xfer();
      vectors++;
      if ({done, busy} !== 2'b00) begin
         miscompares++;
         $display("FAIL %s_idle: got done/busy %b required 00", name, {done, busy});
      end
   endtask

   task automatic test_one_sector();
      t_rand = 0;
      run_full("t1_sector", 32'h1000_0000, 256, 1'b0);
   endtask

   task automatic test_partial_burst();
      run_full("t2_partial", 32'h2000_0000, 36, 1'b0);
   endtask

   task automatic test_odd_halfword();
      run_full("t3_odd", 32'h3000_1000, 3, 1'b0);
   endtask

   task automatic test_stalls();
      t_rand = 1;
      run_full("t4_stalls", 32'h4000_0000, 512, 1'b1);
      t_rand = 0;
   endtask

   task automatic test_overflow_err();
      t_hold_w = 1;
      t_subseq = 1;
      t_bad_b  = 2;
      begin_xfer(32'h5000_0000, 0, 1'b0);
      fork
         send_hw(256, 1'b0);
         begin repeat (200) @(negedge clk); t_hold_w = 0; end
      join
      wait_done(4000);
      vectors++;
      if (done !== 1'b1) begin
         miscompares++;
         $display("FAIL t5_done: got %b required 1", done);
      end
      vectors++;
      if (overflow !== 1'b1) begin
         miscompares++;
         $display("FAIL t5_overflow: got %b required 1", overflow);
      end
      vectors++;
      if (err !== 1'b1) begin
         miscompares++;
         $display("FAIL t5_err: got %b required 1", err);
      end
      vectors++;
      if (exp_q.size() !== 0) begin
         miscompares++;
         $display("FAIL t5_tail: got %0d trailing words unwritten required 0", exp_q.size());
      end
      end_xfer();
      t_subseq = 0;
      t_bad_b  = -1;
   endtask

   task automatic test_abort();
      int  wl0, b0;
      bit  saw_done;
      wl0 = wlast_cnt;
      b0  = b_cnt;
      begin_xfer(32'h6000_0000, 128, 1'b1);
      vectors++;
      if ({overflow, err} !== 2'b00) begin
         miscompares++;
         $display("FAIL t6_flags_cleared: got ovf/err %b required 00", {overflow, err});
      end
      fork
         send_hw(256, 1'b0);
         begin
            for (int i = 0; i < 1000 && aw_cnt - t_aw0 < 2; i++) @(negedge clk);
            vectors++;
            if (aw_cnt - t_aw0 !== 2) begin
               miscompares++;
               $display("FAIL t6_aw2_timeout: got %0d bursts required 2", aw_cnt - t_aw0);
            end
            @(negedge clk);
            start = 1'b0;
         end
      join
      for (int i = 0; i < 200 && busy !== 1'b0; i++) @(negedge clk);
      saw_done = 0;
      repeat (20) begin @(negedge clk); if (done) saw_done = 1; end
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL t6_busy: got %b required 0", busy);
      end
      vectors++;
      if (saw_done !== 1'b0) begin
         miscompares++;
         $display("FAIL t6_done: got %b required 0", saw_done);
      end
      vectors++;
      if (aw_cnt - t_aw0 !== 2 || wlast_cnt - wl0 !== 2 || b_cnt - b0 !== 2) begin
         miscompares++;
         $display("FAIL t6_bursts: got aw/wlast/b %0d/%0d/%0d required 2/2/2",
                  aw_cnt - t_aw0, wlast_cnt - wl0, b_cnt - b0);
      end
      wr_last = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid_burst();
      begin_xfer(32'h7000_0000, 32, 1'b1);
      fork
         send_hw(64, 1'b0);
         begin
            for (int i = 0; i < 500 && aw_cnt - t_aw0 < 1; i++) @(negedge clk);
            @(negedge clk);
            rst   = 1'b1;
            start = 1'b0;
            @(negedge clk);
            vectors++;
            if ({busy, done, overflow, err} !== 4'b0000) begin
               miscompares++;
               $display("FAIL t6_rst_status: got %b required 0000", {busy, done, overflow, err});
            end
            vectors++;
            if ({axi.awvalid, axi.wvalid, axi.wlast, axi.bready} !== 4'b0000) begin
               miscompares++;
               $display("FAIL t6_rst_handshake: got %b required 0000",
                        {axi.awvalid, axi.wvalid, axi.wlast, axi.bready});
            end
            vectors++;
            if ({axi.awaddr, axi.awlen, axi.wdata} !== 72'h0) begin
               miscompares++;
               $display("FAIL t6_rst_bus: got %h required 0", {axi.awaddr, axi.awlen, axi.wdata});
            end
            rst = 1'b0;
         end
      join
      wr_last = 1'b0;
      exp_q.delete();
      repeat (3) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_one_sector();
      test_partial_burst();
      test_odd_halfword();
      test_stalls();
      test_overflow_err();
      test_abort();
      test_reset_mid_burst();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
